// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I(+M) decode stage with main/skid registers, flush and illegal detection
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32,
  parameter int ENABLE_M = 1
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                FLUSH,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [PC_WIDTH-1:0] IN_PC,
  input  logic [31:0]         IN_INSTR,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [PC_WIDTH-1:0] OUT_PC,
  output logic [5:0]          OUT_OP,
  output logic [4:0]          OUT_RD,
  output logic [4:0]          OUT_RS1,
  output logic [4:0]          OUT_RS2,
  output logic [XLEN-1:0]     OUT_IMM,
  output logic                OUT_ILLEGAL
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("decode_stage supports only XLEN=32");
  end

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [5:0]          op;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [XLEN-1:0]     imm;
    logic                ill;
  } entry_t;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [5:0] op;
  fmt_t       fmt;
  entry_t     dec;
  entry_t     m_q, s_q;
  logic       m_valid, s_valid;
  logic       accept;

  assign opc = IN_INSTR[6:0];
  assign f3  = IN_INSTR[14:12];
  assign f7  = IN_INSTR[31:25];

  // Matching the full 7-bit opcode also rejects any word whose low two bits are not 2'b11.
  always_comb begin
    op  = 6'd0;
    fmt = FMT_R;
    case (opc)
      7'b0110111: begin op = 6'd1; fmt = FMT_U; end
      7'b0010111: begin op = 6'd2; fmt = FMT_U; end
      7'b1101111: begin op = 6'd3; fmt = FMT_J; end
      7'b1100111: begin fmt = FMT_I; if (f3 == 3'd0) op = 6'd4; end
      7'b1100011: begin
        fmt = FMT_B;
        case (f3)
          3'd0: op = 6'd5;
          3'd1: op = 6'd6;
          3'd4: op = 6'd7;
          3'd5: op = 6'd8;
          3'd6: op = 6'd9;
          3'd7: op = 6'd10;
          default: op = 6'd0;
        endcase
      end
      7'b0000011: begin
        fmt = FMT_I;
        case (f3)
          3'd0: op = 6'd11;
          3'd1: op = 6'd12;
          3'd2: op = 6'd13;
          3'd4: op = 6'd14;
          3'd5: op = 6'd15;
          default: op = 6'd0;
        endcase
      end
      7'b0100011: begin
        fmt = FMT_S;
        case (f3)
          3'd0: op = 6'd16;
          3'd1: op = 6'd17;
          3'd2: op = 6'd18;
          default: op = 6'd0;
        endcase
      end
      7'b0010011: begin
        fmt = FMT_I;
        case (f3)
          3'd0: op = 6'd19;
          3'd2: op = 6'd20;
          3'd3: op = 6'd21;
          3'd4: op = 6'd22;
          3'd6: op = 6'd23;
          3'd7: op = 6'd24;
          3'd1: if (f7 == 7'b0000000) op = 6'd25;
          3'd5: begin
            if (f7 == 7'b0000000)      op = 6'd26;
            else if (f7 == 7'b0100000) op = 6'd27;
          end
          default: op = 6'd0;
        endcase
      end
      7'b0110011: begin
        fmt = FMT_R;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'd0: op = 6'd28;
            3'd1: op = 6'd30;
            3'd2: op = 6'd31;
            3'd3: op = 6'd32;
            3'd4: op = 6'd33;
            3'd5: op = 6'd34;
            3'd6: op = 6'd36;
            3'd7: op = 6'd37;
            default: op = 6'd0;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'd0)      op = 6'd29;
          else if (f3 == 3'd5) op = 6'd35;
        end else if (f7 == 7'b0000001 && ENABLE_M != 0) begin
          op = 6'd38 + {3'b000, f3};
        end
      end
      default: op = 6'd0;
    endcase
  end

  always_comb begin
    dec     = '0;
    dec.pc  = IN_PC;
    dec.op  = op;
    dec.ill = (op == 6'd0);
    if (op != 6'd0) begin
      if (fmt != FMT_S && fmt != FMT_B)                   dec.rd  = IN_INSTR[11:7];
      if (fmt != FMT_U && fmt != FMT_J)                   dec.rs1 = IN_INSTR[19:15];
      if (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B)   dec.rs2 = IN_INSTR[24:20];
      case (fmt)
        FMT_I: dec.imm = {{20{IN_INSTR[31]}}, IN_INSTR[31:20]};
        FMT_S: dec.imm = {{20{IN_INSTR[31]}}, IN_INSTR[31:25], IN_INSTR[11:7]};
        FMT_B: dec.imm = {{20{IN_INSTR[31]}}, IN_INSTR[7], IN_INSTR[30:25], IN_INSTR[11:8], 1'b0};
        FMT_U: dec.imm = {IN_INSTR[31:12], 12'b0};
        FMT_J: dec.imm = {{12{IN_INSTR[31]}}, IN_INSTR[19:12], IN_INSTR[20], IN_INSTR[30:21], 1'b0};
        default: dec.imm = '0;
      endcase
    end
  end

  assign IN_READY = RSTN & ~s_valid;
  assign accept   = IN_VALID & IN_READY;

  // S only ever fills while M is stalled, so M always holds the oldest entry.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
    end else if (FLUSH) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || OUT_READY) begin
      if (s_valid) begin
        m_q     <= s_q;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_q     <= dec;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      s_q     <= dec;
      s_valid <= 1'b1;
    end
  end

  assign OUT_VALID   = m_valid;
  assign OUT_PC      = m_q.pc;
  assign OUT_OP      = m_q.op;
  assign OUT_RD      = m_q.rd;
  assign OUT_RS1     = m_q.rs1;
  assign OUT_RS2     = m_q.rs2;
  assign OUT_IMM     = m_q.imm;
  assign OUT_ILLEGAL = m_q.ill;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage, ENABLE_M=1 and ENABLE_M=0 side by side
module tb_decode_stage;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ill;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc;
    dec_t        d1;
    dec_t        d0;
  } exp_t;

  // Match patterns in op-code order: entry k-1 is op k.
  localparam logic [31:0] MATCH [45] = '{
    32'h00000037, 32'h00000017, 32'h0000006F, 32'h00000067,
    32'h00000063, 32'h00001063, 32'h00004063, 32'h00005063, 32'h00006063, 32'h00007063,
    32'h00000003, 32'h00001003, 32'h00002003, 32'h00004003, 32'h00005003,
    32'h00000023, 32'h00001023, 32'h00002023,
    32'h00000013, 32'h00002013, 32'h00003013, 32'h00004013, 32'h00006013, 32'h00007013,
    32'h00001013, 32'h00005013, 32'h40005013,
    32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033, 32'h00003033,
    32'h00004033, 32'h00005033, 32'h40005033, 32'h00006033, 32'h00007033,
    32'h02000033, 32'h02001033, 32'h02002033, 32'h02003033,
    32'h02004033, 32'h02005033, 32'h02006033, 32'h02007033
  };

  logic        CLK = 1'b0;
  logic        RSTN, FLUSH, IN_VALID;
  logic [31:0] IN_PC, IN_INSTR;
  logic        OUT_READY;
  logic        ready_force = 1'b1, rand_ready = 1'b0, rnd_ready = 1'b1;
  logic        mon_en = 1'b0;

  logic        IN_READY, OUT_VALID, OUT_ILLEGAL;
  logic [31:0] OUT_PC, OUT_IMM;
  logic [5:0]  OUT_OP;
  logic [4:0]  OUT_RD, OUT_RS1, OUT_RS2;
  logic        z_in_ready, z_valid, z_ill;
  logic [31:0] z_pc, z_imm;
  logic [5:0]  z_op;
  logic [4:0]  z_rd, z_rs1, z_rs2;

  int   checks = 0, failures = 0;
  exp_t sb[$];

  always #5 CLK = ~CLK;
  assign OUT_READY = rand_ready ? rnd_ready : ready_force;
  always @(posedge CLK) begin
    #1;
    rnd_ready <= ($urandom_range(0, 3) != 0);
  end

  decode_stage #(.XLEN(32), .PC_WIDTH(32), .ENABLE_M(1)) dut (
    .CLK(CLK), .RSTN(RSTN), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_PC(IN_PC), .IN_INSTR(IN_INSTR), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_PC(OUT_PC), .OUT_OP(OUT_OP), .OUT_RD(OUT_RD), .OUT_RS1(OUT_RS1), .OUT_RS2(OUT_RS2),
    .OUT_IMM(OUT_IMM), .OUT_ILLEGAL(OUT_ILLEGAL));

  decode_stage #(.XLEN(32), .PC_WIDTH(32), .ENABLE_M(0)) dut_m0 (
    .CLK(CLK), .RSTN(RSTN), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(z_in_ready),
    .IN_PC(IN_PC), .IN_INSTR(IN_INSTR), .OUT_VALID(z_valid), .OUT_READY(OUT_READY),
    .OUT_PC(z_pc), .OUT_OP(z_op), .OUT_RD(z_rd), .OUT_RS1(z_rs1), .OUT_RS2(z_rs2),
    .OUT_IMM(z_imm), .OUT_ILLEGAL(z_ill));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(input int op);
    if (op <= 3)       return 32'h0000007F;
    else if (op <= 24) return 32'h0000707F;
    else               return 32'hFE00707F;
  endfunction

  function automatic dec_t model(input logic [31:0] w, input bit en_m);
    dec_t d = '0;
    int   op = 0;
    bit   r, i, s, b, u, j;
    for (int k = 1; k <= 45; k++)
      if ((w & mask_of(k)) == MATCH[k-1]) op = k;
    if (op >= 38 && !en_m) op = 0;
    if (op == 0) begin
      d.ill = 1'b1;
      return d;
    end
    u = (op <= 2);
    j = (op == 3);
    b = (op >= 5 && op <= 10);
    s = (op >= 16 && op <= 18);
    r = (op >= 28);
    i = !(u || j || b || s || r);
    d.op = op[5:0];
    if (r || i || u || j) d.rd  = w[11:7];
    if (r || i || s || b) d.rs1 = w[19:15];
    if (r || s || b)      d.rs2 = w[24:20];
    if (i) d.imm = {{20{w[31]}}, w[31:20]};
    if (s) d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
    if (b) d.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    if (u) d.imm = {w[31:12], 12'b0};
    if (j) d.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    return d;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int          k = $urandom_range(0, 9);
    int          idx = $urandom_range(0, 44);
    w = $urandom;
    if (k == 0) return w;
    if (k == 1) begin
      w[1:0] = 2'($urandom_range(0, 2));
      return w;
    end
    return MATCH[idx] | (w & ~mask_of(idx + 1));
  endfunction

  // Holds IN_VALID until the handshake completes, then records the expectation at the accepting edge.
  task automatic send(input logic [31:0] pc, input logic [31:0] w);
    bit   ok = 1'b0;
    exp_t e;
    IN_VALID = 1'b1;
    IN_PC    = pc;
    IN_INSTR = w;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge CLK);
      ok = IN_READY && RSTN && !FLUSH;
      @(posedge CLK);
    end
    if (ok) begin
      e.pc = pc;
      e.d1 = model(w, 1'b1);
      e.d0 = model(w, 1'b0);
      sb.push_back(e);
    end else begin
      chk("send_timeout", 64'd0, 64'd1);
    end
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic expect_m1(input string name, input logic [5:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    @(negedge CLK);
    chk({name, "_valid"}, OUT_VALID, 1'b1);
    chk({name, "_op"}, OUT_OP, op);
    chk({name, "_rd"}, OUT_RD, rd);
    chk({name, "_rs1"}, OUT_RS1, rs1);
    chk({name, "_rs2"}, OUT_RS2, rs2);
    chk({name, "_imm"}, OUT_IMM, imm);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_m1"}, {OUT_VALID, OUT_PC, OUT_OP, OUT_RD, OUT_RS1, OUT_RS2, OUT_IMM, OUT_ILLEGAL}, 64'd0);
    chk({name, "_m0"}, {z_valid, z_pc, z_op, z_rd, z_rs1, z_rs2, z_imm, z_ill}, 64'd0);
    chk({name, "_in_ready"}, IN_READY, 1'b0);
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      chk("out_valid", OUT_VALID, sb.size() != 0);
      chk("out_valid_m0", z_valid, sb.size() != 0);
      chk("in_ready", IN_READY, RSTN && sb.size() < 2);
      chk("in_ready_m0", z_in_ready, RSTN && sb.size() < 2);
      if (OUT_VALID && sb.size() != 0) begin
        chk("out_pc", OUT_PC, sb[0].pc);
        chk("dec_m1", {OUT_OP, OUT_RD, OUT_RS1, OUT_RS2, OUT_IMM, OUT_ILLEGAL}, sb[0].d1);
        chk("dec_m0", {z_op, z_rd, z_rs1, z_rs2, z_imm, z_ill}, sb[0].d0);
      end
      if (!RSTN || FLUSH) sb.delete();
      else if (OUT_VALID && OUT_READY && sb.size() != 0) void'(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTN = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; IN_PC = '0; IN_INSTR = '0;
    @(posedge CLK); #1; mon_en = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK); check_zero("reset");
    @(posedge CLK); #1; RSTN = 1'b1;
    @(negedge CLK); chk("ready_after_reset", IN_READY, 1'b1);
    @(posedge CLK); #1;

    send(32'h100, 32'hFFF00093);
    expect_m1("addi", 6'd19, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
    send(32'h104, 32'hFE208EE3);
    expect_m1("beq", 6'd5, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    send(32'h108, 32'h123452B7);
    expect_m1("lui", 6'd1, 5'd5, 5'd0, 5'd0, 32'h12345000);

    send(32'h10C, 32'h022081B3);
    @(negedge CLK);
    chk("mul_m1_op", OUT_OP, 6'd38);
    chk("mul_m1_rd", OUT_RD, 5'd3);
    chk("mul_m0", {z_ill, z_op, z_rd}, {1'b1, 6'd0, 5'd0});
    @(posedge CLK); #1;
    send(32'h110, 32'h00000000);
    @(negedge CLK);
    chk("zero_word", {OUT_ILLEGAL, z_ill, OUT_OP, OUT_PC}, {1'b1, 1'b1, 6'd0, 32'h110});
    @(posedge CLK); #1;

    ready_force = 1'b0;
    fork
      begin
        send(32'h200, 32'h00A00513);
        send(32'h204, 32'h00B50633);
        send(32'h208, 32'h00C62023);
        send(32'h20C, 32'h0000006F);
      end
      begin
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("stall_in_ready", IN_READY, 1'b0);
        chk("stall_head_pc", OUT_PC, 32'h200);
        @(posedge CLK); #1;
        ready_force = 1'b1;
      end
    join
    repeat (4) @(posedge CLK); #1;

    ready_force = 1'b0;
    send(32'h300, 32'h00100093);
    send(32'h304, 32'h00200113);
    IN_VALID = 1'b1; IN_PC = 32'h308; IN_INSTR = 32'h00300193; FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0; IN_VALID = 1'b0;
    @(negedge CLK);
    chk("flush_valid", OUT_VALID, 1'b0);
    chk("flush_ready", IN_READY, 1'b1);
    @(posedge CLK); #1; ready_force = 1'b1;
    repeat (3) @(posedge CLK); #1;

    ready_force = 1'b0;
    send(32'h400, 32'h00400213);
    send(32'h404, 32'h00500293);
    RSTN = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK); check_zero("stall_reset");
    @(posedge CLK); #1; RSTN = 1'b1; ready_force = 1'b1;

    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK); #1;
      end
      send($urandom, rand_word());
    end
    rand_ready = 1'b0;
    for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge CLK);
    #1;
    chk("drain", sb.size(), 0);
    @(negedge CLK);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
